led_mode_seq: RTL and testbench

//  Produces the 3-bit LED mode and the two blink waveforms that the LED output
//  mux consumes: state, pattern1 and pattern2.
//  A debounced push-button steps the mode OFF -> ON -> PATTERN1 -> PATTERN2 -> OFF.
//  A free-running prescaler produces a millisecond tick that times debounce and blinking.

---
 rtl/led_mode_seq.sv | 210 +++++++++++++++++++++
 tb/tb_led_mode_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/led_mode_seq.sv
// rtl/led_mode_seq.sv - button-stepped LED mode sequencer with millisecond blink generators
// Optional feature macro: LED_MODE_AUTO_OFF_EN (idle timer that returns the mode to OFF)
module led_mode_seq #(
  parameter int PRESCALE    = 12000,
  parameter int DEBOUNCE_MS = 20,
  parameter int BLINK1_MS   = 500,
  parameter int BLINK2_MS   = 100,
  parameter int AUTO_OFF_MS = 60000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  output logic [2:0] state,
  output logic       pattern1,
  output logic       pattern2,
  output logic       mode_stb
);

  // Counter widths sized to hold their largest value
  localparam int PS_W = $clog2(PRESCALE);
  localparam int DB_W = $clog2(DEBOUNCE_MS + 1);
  localparam int B1_W = $clog2(BLINK1_MS + 1);
  localparam int B2_W = $clog2(BLINK2_MS + 1);

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_MS);
  localparam logic [B1_W-1:0] B1_LAST = B1_W'(BLINK1_MS - 1);
  localparam logic [B2_W-1:0] B2_LAST = B2_W'(BLINK2_MS - 1);

  typedef enum logic [2:0] {
    S_OFF = 3'b000,
    S_ON  = 3'b001,
    S_P1  = 3'b010,
    S_P2  = 3'b011
  } mode_e;

  logic [PS_W-1:0] ps_q, ps_d;
  logic            tick;
  logic [1:0]      sync_q;
  logic            btn_s;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            btn_db_q, btn_db_d;
  logic            btn_db_prev_q;
  logic            press;
  logic [B1_W-1:0] b1_cnt_q, b1_cnt_d;
  logic [B2_W-1:0] b2_cnt_q, b2_cnt_d;
  logic            p1_q, p1_d;
  logic            p2_q, p2_d;
  logic            timeout;
  mode_e           state_q;
  logic            mode_stb_q;

  // Prescaler next count; tick strobes on the last count of each period
  always_comb begin
    tick = (ps_q == PS_LAST);
    ps_d = tick ? '0 : ps_q + PS_W'(1);
  end

  // Prescaler register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ps_q <= '0;
    else     ps_q <= ps_d;
  end

  // Two-flop synchronizer for the asynchronous button pin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], btn};
  end

  assign btn_s = sync_q[1];

  // Debounce: any clk where the input agrees with the accepted level restarts
  // the window; a disagreement that survives DEBOUNCE_MS ticks is accepted.
  // The counter stops at DB_MAX, so it cannot wrap.
  always_comb begin
    db_cnt_d = db_cnt_q;
    btn_db_d = btn_db_q;
    if (btn_s == btn_db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_MAX) begin
      btn_db_d = btn_s;
      db_cnt_d = '0;
    end else if (tick) begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  // Debounce registers plus the delayed copy used for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt_q      <= '0;
      btn_db_q      <= 1'b0;
      btn_db_prev_q <= 1'b0;
    end else begin
      db_cnt_q      <= db_cnt_d;
      btn_db_q      <= btn_db_d;
      btn_db_prev_q <= btn_db_q;
    end
  end

  // Only the accepted press edge matters; releases and holds are ignored
  assign press = btn_db_q & ~btn_db_prev_q;

  // Pattern1 half-period counter and toggle
  always_comb begin
    b1_cnt_d = b1_cnt_q;
    p1_d     = p1_q;
    if (tick) begin
      if (b1_cnt_q == B1_LAST) begin
        b1_cnt_d = '0;
        p1_d     = ~p1_q;
      end else begin
        b1_cnt_d = b1_cnt_q + B1_W'(1);
      end
    end
  end

  // Pattern2 half-period counter and toggle
  always_comb begin
    b2_cnt_d = b2_cnt_q;
    p2_d     = p2_q;
    if (tick) begin
      if (b2_cnt_q == B2_LAST) begin
        b2_cnt_d = '0;
        p2_d     = ~p2_q;
      end else begin
        b2_cnt_d = b2_cnt_q + B2_W'(1);
      end
    end
  end

  // Blink registers; free-running so the LED mux only has to select them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b1_cnt_q <= '0;
      b2_cnt_q <= '0;
      p1_q     <= 1'b0;
      p2_q     <= 1'b0;
    end else begin
      b1_cnt_q <= b1_cnt_d;
      b2_cnt_q <= b2_cnt_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
    end
  end

`ifdef LED_MODE_AUTO_OFF_EN
  localparam int IDLE_W = $clog2(AUTO_OFF_MS + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(AUTO_OFF_MS);

  logic [IDLE_W-1:0] idle_q, idle_d;

  // Idle timer: a press or the OFF mode restarts it, so a press arriving in
  // the timeout cycle wins and the timer starts over
  always_comb begin
    idle_d  = idle_q;
    timeout = 1'b0;
    if (press || (state_q == S_OFF)) begin
      idle_d = '0;
    end else if (idle_q == IDLE_MAX) begin
      timeout = 1'b1;
      idle_d  = '0;
    end else if (tick) begin
      idle_d = idle_q + IDLE_W'(1);
    end
  end

  // Idle timer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) idle_q <= '0;
    else     idle_q <= idle_d;
  end
`else
  // No idle timer in this build; AUTO_OFF_MS has no effect
  assign timeout = 1'b0 & (AUTO_OFF_MS != 0);
`endif

  // Mode FSM with registered strobe; press beats timeout, illegal codes fall back to OFF
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_OFF;
      mode_stb_q <= 1'b0;
    end else begin
      mode_stb_q <= 1'b0;
      if (press) begin
        mode_stb_q <= 1'b1;
        case (state_q)
          S_OFF:   state_q <= S_ON;
          S_ON:    state_q <= S_P1;
          S_P1:    state_q <= S_P2;
          S_P2:    state_q <= S_OFF;
          default: state_q <= S_OFF;
        endcase
      end else if (timeout) begin
        state_q    <= S_OFF;
        mode_stb_q <= 1'b1;
      end else if (!(state_q inside {S_OFF, S_ON, S_P1, S_P2})) begin
        state_q    <= S_OFF;
        mode_stb_q <= 1'b1;
      end
    end
  end

  assign state    = state_q;
  assign pattern1 = p1_q;
  assign pattern2 = p2_q;
  assign mode_stb = mode_stb_q;

endmodule

// File: tb/tb_led_mode_seq.sv
// tb/tb_led_mode_seq.sv - directed table-driven bench for led_mode_seq
module tb_led_mode_seq;

`ifdef LED_MODE_AUTO_OFF_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       btn;
  logic [2:0] state;
  logic       pattern1;
  logic       pattern2;
  logic       mode_stb;

  int checks;
  int errors;
  int stb_seen;

  typedef struct {
    logic btn;
    int   hold;
    int   exp_state;
    int   exp_stb;
  } vec_t;

  vec_t vecs[12];

  led_mode_seq #(
    .PRESCALE   (4),
    .DEBOUNCE_MS(3),
    .BLINK1_MS  (5),
    .BLINK2_MS  (2),
    .AUTO_OFF_MS(20)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn),
    .state   (state),
    .pattern1(pattern1),
    .pattern2(pattern2),
    .mode_stb(mode_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Advance n clocks, sampling 1 time unit after each rising edge
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (mode_stb === 1'b1) stb_seen++;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " state"}, int'(state), 0);
    check({tag, " pattern1"}, int'(pattern1), 0);
    check({tag, " pattern2"}, int'(pattern2), 0);
    check({tag, " mode_stb"}, int'(mode_stb), 0);
  endtask

  initial begin
    int s0;
    int waited;
    checks   = 0;
    errors   = 0;
    stb_seen = 0;

    // press sequence OFF->ON->P1->P2->OFF, then glitch, then long hold
    vecs[0]  = '{1'b1, 30, 1, 1};
    vecs[1]  = '{1'b0, 30, 1, 0};
    vecs[2]  = '{1'b1, 30, 2, 1};
    vecs[3]  = '{1'b0, 30, 2, 0};
    vecs[4]  = '{1'b1, 30, 3, 1};
    vecs[5]  = '{1'b0, 30, 3, 0};
    vecs[6]  = '{1'b1, 30, 0, 1};
    vecs[7]  = '{1'b0, 30, 0, 0};
    vecs[8]  = '{1'b1, 6, 0, 0};
    vecs[9]  = '{1'b0, 30, 0, 0};
    vecs[10] = '{1'b1, 500, AUTO ? 0 : 1, AUTO ? 2 : 1};
    vecs[11] = '{1'b0, 30, AUTO ? 0 : 1, 0};

    // Reset held with the clock running and the button wiggling
    rst = 1'b1;
    btn = 1'b0;
    step(1);
    btn = 1'b1;
    step(1);
    btn = 1'b0;
    step(2);
    check_zero("reset");

    // Free run: edge n after release gives pattern1=(n/20)%2, pattern2=(n/8)%2
    rst = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      step(1);
      check($sformatf("freerun p1 n=%0d", n), int'(pattern1), (n / 20) % 2);
      check($sformatf("freerun p2 n=%0d", n), int'(pattern2), (n / 8) % 2);
    end
    check("freerun state", int'(state), 0);
    check("freerun stb", stb_seen, 0);

    // Table of button levels, durations and expected outcomes
    for (int i = 0; i < 12; i++) begin
      btn = vecs[i].btn;
      s0  = stb_seen;
      step(vecs[i].hold);
      check($sformatf("vec%0d state", i), int'(state), vecs[i].exp_state);
      check($sformatf("vec%0d stb", i), stb_seen - s0, vecs[i].exp_stb);
    end

    // Asynchronous reset mid-cycle while the button is held
    btn = 1'b1;
    s0  = stb_seen;
    step(30);
    check("prereset state", int'(state), AUTO ? 1 : 2);
    check("prereset stb", stb_seen - s0, 1);
    #3;
    rst = 1'b1;
    #1;
    check_zero("async reset");
    btn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check_zero($sformatf("reset hold %0d", i));
    end
    rst = 1'b0;
    s0  = stb_seen;
    step(30);
    check("postreset state", int'(state), 0);
    check("postreset stb", stb_seen - s0, 0);

    // Auto-off: press to ON, then stay idle
    btn = 1'b1;
    s0  = stb_seen;
    step(30);
    check("idle press state", int'(state), 1);
    check("idle press stb", stb_seen - s0, 1);
    btn    = 1'b0;
    s0     = stb_seen;
    waited = 0;
    if (AUTO) begin
      while (state !== 3'b000 && waited < 200) begin
        step(1);
        waited++;
      end
      check("autooff state", int'(state), 0);
      check("autooff not early", int'(waited >= 40), 1);
      step(2);
      check("autooff stb", stb_seen - s0, 1);
    end else begin
      step(200);
      check("no autooff state", int'(state), 1);
      check("no autooff stb", stb_seen - s0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
